// File: rtl/ps2_host_tx_if.sv
// Command/handshake and PS/2 pin bundle for the host-to-device transmitter.
// The slave side is the transmitter; the master side is the logic that
// issues commands and owns the physical open-collector pins.
interface ps2_host_tx_if;
   logic [7:0] txData;
   logic       txStart;
   logic       txBusy;
   logic       txDone;
   logic       txError;
   logic       PS2_CLK_IN;
   logic       PS2_DAT_IN;
   logic       PS2_CLK_DRIVE_LOW;
   logic       PS2_DAT_DRIVE_LOW;

   modport master (
      output txData,
      output txStart,
      input  txBusy,
      input  txDone,
      input  txError,
      output PS2_CLK_IN,
      output PS2_DAT_IN,
      input  PS2_CLK_DRIVE_LOW,
      input  PS2_DAT_DRIVE_LOW
   );

   modport slave (
      input  txData,
      input  txStart,
      output txBusy,
      output txDone,
      output txError,
      input  PS2_CLK_IN,
      input  PS2_DAT_IN,
      output PS2_CLK_DRIVE_LOW,
      output PS2_DAT_DRIVE_LOW
   );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Performs the request-to-send sequence
// (inhibit clock, pull data low, release clock), then presents one data bit
// per device-generated falling clock edge: D0..D7, odd parity, stop. The
// device acknowledge is sampled on the 11th falling edge. Any gap between
// device events longer than TIMEOUT_CYCLES aborts the transfer with an error.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic           clk,
   input  logic           rst,
   ps2_host_tx_if.slave   bus
);

   // One timer is shared by the inhibit phase and the event timeout, so it
   // must be wide enough for whichever count is larger.
   localparam int unsigned TIMER_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ?
                                       TIMEOUT_CYCLES : INHIBIT_CYCLES;
   localparam int TW = $clog2(TIMER_MAX + 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_REQ,
      ST_SHIFT,
      ST_ACK,
      ST_WAIT_IDLE
   } state_t;

   state_t          state_reg;
   logic [7:0]      data_reg;
   logic [3:0]      edge_cnt_reg;
   logic [TW-1:0]   timer_reg;
   logic            busy_reg;
   logic            done_reg;
   logic            error_reg;
   logic            nack_reg;
   logic            clk_drv_reg;
   logic            dat_drv_reg;

   logic [1:0]      clk_sync_reg;
   logic [1:0]      dat_sync_reg;
   logic            clk_prev_reg;

   logic            clk_s;
   logic            dat_s;
   logic            fall;
   logic            parity;

   assign clk_s  = clk_sync_reg[1];
   assign dat_s  = dat_sync_reg[1];
   assign fall   = clk_prev_reg & ~clk_s;
   assign parity = ~^data_reg;

   assign bus.txBusy            = busy_reg;
   assign bus.txDone            = done_reg;
   assign bus.txError           = error_reg;
   assign bus.PS2_CLK_DRIVE_LOW = clk_drv_reg;
   assign bus.PS2_DAT_DRIVE_LOW = dat_drv_reg;

   // Two-stage synchronizers for the raw pins plus the previous synced clock
   // used for falling-edge detection; idle bus level is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync_reg <= 2'b11;
         dat_sync_reg <= 2'b11;
         clk_prev_reg <= 1'b1;
      end else begin
         clk_sync_reg <= {clk_sync_reg[0], bus.PS2_CLK_IN};
         dat_sync_reg <= {dat_sync_reg[0], bus.PS2_DAT_IN};
         clk_prev_reg <= clk_s;
      end
   end

   // Transfer state machine with registered pin drives and status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         data_reg     <= 8'h00;
         edge_cnt_reg <= 4'd0;
         timer_reg    <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         error_reg    <= 1'b0;
         nack_reg     <= 1'b0;
         clk_drv_reg  <= 1'b0;
         dat_drv_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               clk_drv_reg <= 1'b0;
               dat_drv_reg <= 1'b0;
               // busy is still high in the txDone cycle; a request seen
               // then is dropped so the pulse cannot overlap a new frame.
               if (busy_reg) begin
                  busy_reg <= 1'b0;
               end else if (bus.txStart) begin
                  data_reg     <= bus.txData;
                  edge_cnt_reg <= 4'd0;
                  timer_reg    <= '0;
                  busy_reg     <= 1'b1;
                  error_reg    <= 1'b0;
                  nack_reg     <= 1'b0;
                  clk_drv_reg  <= 1'b1;
                  state_reg    <= ST_INHIBIT;
               end
            end

            ST_INHIBIT: begin
               if (timer_reg == INHIBIT_LAST) begin
                  timer_reg   <= '0;
                  dat_drv_reg <= 1'b1;
                  state_reg   <= ST_REQ;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end

            ST_REQ: begin
               // Releasing the clock with data held low is the start bit.
               clk_drv_reg <= 1'b0;
               timer_reg   <= '0;
               state_reg   <= ST_SHIFT;
            end

            ST_SHIFT: begin
               if (fall) begin
                  timer_reg    <= '0;
                  edge_cnt_reg <= edge_cnt_reg + 4'd1;
                  case (edge_cnt_reg)
                     4'd0, 4'd1, 4'd2, 4'd3,
                     4'd4, 4'd5, 4'd6, 4'd7: dat_drv_reg <= ~data_reg[edge_cnt_reg[2:0]];
                     4'd8:                   dat_drv_reg <= ~parity;
                     default: begin
                        dat_drv_reg <= 1'b0;
                        state_reg   <= ST_ACK;
                     end
                  endcase
               end else if (timer_reg == TIMEOUT_LAST) begin
                  clk_drv_reg <= 1'b0;
                  dat_drv_reg <= 1'b0;
                  done_reg    <= 1'b1;
                  error_reg   <= 1'b1;
                  state_reg   <= ST_IDLE;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end

            ST_ACK: begin
               if (fall) begin
                  nack_reg  <= dat_s;
                  timer_reg <= '0;
                  state_reg <= ST_WAIT_IDLE;
               end else if (timer_reg == TIMEOUT_LAST) begin
                  done_reg  <= 1'b1;
                  error_reg <= 1'b1;
                  state_reg <= ST_IDLE;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end

            ST_WAIT_IDLE: begin
               if (clk_s && dat_s) begin
                  done_reg  <= 1'b1;
                  error_reg <= nack_reg;
                  state_reg <= ST_IDLE;
               end else if (timer_reg == TIMEOUT_LAST) begin
                  done_reg  <= 1'b1;
                  error_reg <= 1'b1;
                  state_reg <= ST_IDLE;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end

            default: begin
               clk_drv_reg <= 1'b0;
               dat_drv_reg <= 1'b0;
               state_reg   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
